// File: rtl/ajuste_hora.sv
// ---------------------------------------------------------------------------
// ajuste_hora -- time-of-day keeper with button-driven field adjustment.
//
// Keeps HH:MM:SS running from a 1 Hz tick. A mode button walks through
// RUN -> ADJ_H -> ADJ_M -> ADJ_S -> RUN. In an adjust state the time is
// frozen, the selected field is stepped with up/down (wrapping inside the
// field, never carrying), and its blank flag follows `blink` so the
// renderer flashes the digits being edited.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low; clears all state
//   tick      1 Hz single-cycle pulse, synchronous to clk
//   btn_mode  debounced mode button level (asynchronous)
//   btn_up    debounced up button level (asynchronous)
//   btn_down  debounced down button level (asynchronous)
//   blink     slow toggle from the blink counter
//   adj_en    high in any adjust state; enables the blink counter
//   mode      0 RUN, 1 ADJ_H, 2 ADJ_M, 3 ADJ_S
//   hours     0..HOUR_MAX
//   minutes   0..MIN_MAX
//   seconds   0..MIN_MAX
//   blank_h/m/s  blank the matching digits this frame
// ---------------------------------------------------------------------------
module ajuste_hora #(
   parameter int HOUR_MAX = 23,
   parameter int MIN_MAX  = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       blink,
   output logic       adj_en,
   output logic [1:0] mode,
   output logic [4:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic       blank_h,
   output logic       blank_m,
   output logic       blank_s
);

   localparam logic [4:0] H_MAX = 5'(HOUR_MAX);
   localparam logic [5:0] M_MAX = 6'(MIN_MAX);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      ADJ_H = 2'd1,
      ADJ_M = 2'd2,
      ADJ_S = 2'd3
   } mode_t;

   // Button vectors: bit 0 = mode, bit 1 = up, bit 2 = down.
   logic [2:0] s1, s2, s3;
   logic [2:0] press;
   logic       p_mode, step_up, step_dn;

   mode_t      state, state_next;
   logic [4:0] h_next;
   logic [5:0] m_next, s_next;

   // Two flops resynchronise the asynchronous levels; s3 holds the previous
   // synchronised value so a held button gives a single press.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its neighbours; blocking here would collapse the chain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= {btn_down, btn_up, btn_mode};
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign press  = s2 & ~s3;
   assign p_mode = press[0];
   // A mode press swallows any step, and opposing steps cancel out.
   assign step_up = press[1] & ~press[2] & ~p_mode;
   assign step_dn = press[2] & ~press[1] & ~p_mode;

   // Field helpers: >= so a forced out-of-range value wraps to 0 on increment.
   function automatic logic [5:0] inc_ms(input logic [5:0] v);
      return (v >= M_MAX) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [5:0] dec_ms(input logic [5:0] v);
      return (v == 6'd0) ? M_MAX : v - 6'd1;
   endfunction

   function automatic logic [4:0] inc_h(input logic [4:0] v);
      return (v >= H_MAX) ? 5'd0 : v + 5'd1;
   endfunction

   function automatic logic [4:0] dec_h(input logic [4:0] v);
      return (v == 5'd0) ? H_MAX : v - 5'd1;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= RUN;
         hours   <= '0;
         minutes <= '0;
         seconds <= '0;
      end else begin
         state   <= state_next;
         hours   <= h_next;
         minutes <= m_next;
         seconds <= s_next;
      end
   end

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      h_next     = hours;
      m_next     = minutes;
      s_next     = seconds;

      if (p_mode) begin
         unique case (state)
            RUN:   state_next = ADJ_H;
            ADJ_H: state_next = ADJ_M;
            ADJ_M: state_next = ADJ_S;
            ADJ_S: state_next = RUN;
         endcase
      end

      // The update is keyed on the current state, so a tick landing with the
      // mode press in RUN still counts while the state advances.
      unique case (state)
         RUN: begin
            if (tick) begin
               s_next = inc_ms(seconds);
               if (seconds >= M_MAX) begin
                  m_next = inc_ms(minutes);
                  if (minutes >= M_MAX) begin
                     h_next = inc_h(hours);
                  end
               end
            end
         end
         ADJ_H: begin
            if (step_up)      h_next = inc_h(hours);
            else if (step_dn) h_next = dec_h(hours);
         end
         ADJ_M: begin
            if (step_up)      m_next = inc_ms(minutes);
            else if (step_dn) m_next = dec_ms(minutes);
         end
         ADJ_S: begin
            if (step_up)      s_next = inc_ms(seconds);
            else if (step_dn) s_next = dec_ms(seconds);
         end
      endcase
   end

   assign mode    = state;
   assign adj_en  = (state != RUN);
   assign blank_h = (state == ADJ_H) & blink;
   assign blank_m = (state == ADJ_M) & blink;
   assign blank_s = (state == ADJ_S) & blink;

endmodule

// File: tb/tb_ajuste_hora.sv
// ---------------------------------------------------------------------------
// tb_ajuste_hora -- self-checking bench for ajuste_hora.
//
// A behavioural model holds the time as plain integers and recomputes the
// press events from the raw button history; a compare process checks every
// output against it each cycle. Directed literal checks pin key values.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps

module tb_ajuste_hora;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       blink = 1'b0;
   logic       adj_en;
   logic [1:0] mode;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       blank_h, blank_m, blank_s;

   int n_vec  = 0;
   int n_fail = 0;

   ajuste_hora #(.HOUR_MAX(23), .MIN_MAX(59)) dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .btn_mode (btn_mode),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .blink    (blink),
      .adj_en   (adj_en),
      .mode     (mode),
      .hours    (hours),
      .minutes  (minutes),
      .seconds  (seconds),
      .blank_h  (blank_h),
      .blank_m  (blank_m),
      .blank_s  (blank_s)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_mode = 0;
   int m_h = 0, m_m = 0, m_s = 0;
   // hist[k][b]: button b as seen k+1 edges ago (b: 0 mode, 1 up, 2 down)
   bit [2:0] hist [3];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
         for (int k = 0; k < 3; k++) hist[k] = '0;
      end else begin
         bit [2:0] pr;
         int       tod;
         // A level seen two edges ago that was absent three edges ago acts now.
         pr = hist[1] & ~hist[2];
         if (m_mode == 0 && tick) begin
            tod = ((m_h * 3600 + m_m * 60 + m_s) + 1) % 86400;
            m_h = tod / 3600;
            m_m = (tod / 60) % 60;
            m_s = tod % 60;
         end else if (m_mode != 0 && !pr[0] && (pr[1] != pr[2])) begin
            int d;
            d = pr[1] ? 1 : -1;
            case (m_mode)
               1: m_h = (m_h + d + 24) % 24;
               2: m_m = (m_m + d + 60) % 60;
               default: m_s = (m_s + d + 60) % 60;
            endcase
         end
         if (pr[0]) m_mode = (m_mode + 1) % 4;
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = {btn_down, btn_up, btn_mode};
      end
   end

   // Per-cycle comparison, well clear of both clock edges.
   always @(posedge clk) begin
      #3;
      if (reset) begin
         check("mode",    int'(mode),    m_mode);
         check("hours",   int'(hours),   m_h);
         check("minutes", int'(minutes), m_m);
         check("seconds", int'(seconds), m_s);
         check("adj_en",  int'(adj_en),  int'(m_mode != 0));
         check("blank_h", int'(blank_h), int'(m_mode == 1 && blink));
         check("blank_m", int'(blank_m), int'(m_mode == 2 && blink));
         check("blank_s", int'(blank_s), int'(m_mode == 3 && blink));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic press(input bit pm, input bit pu, input bit pd);
      @(negedge clk);
      btn_mode = pm; btn_up = pu; btn_down = pd;
      repeat (4) @(negedge clk);
      btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_tick();
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic check_time(input string name, input int h, input int m, input int s);
      check({name, ".h"}, int'(hours),   h);
      check({name, ".m"}, int'(minutes), m);
      check({name, ".s"}, int'(seconds), s);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      #1 reset = 1'b0;
      #2;
      check("rst.mode", int'(mode), 0);
      check("rst.adj_en", int'(adj_en), 0);
      check_time("rst", 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // Mode cycling with latency check on each press (held 10 cycles).
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         btn_mode = 1'b1;
         @(posedge clk);
         @(posedge clk); #1;
         check("mode.lat_before", int'(mode), i - 1);
         @(posedge clk); #1;
         check("mode.lat_after", int'(mode), i % 4);
         check("mode.adj_en", int'(adj_en), int'(i % 4 != 0));
         repeat (8) @(negedge clk);
         btn_mode = 1'b0;
         repeat (4) @(negedge clk);
         check("mode.once", int'(mode), i % 4);
      end

      // ADJ_H: down from 0 wraps to 23, up wraps back to 0, then down again.
      press(1, 0, 0);
      press(0, 0, 1);
      check("adjh.down_wrap", int'(hours), 23);
      press(0, 1, 0);
      check("adjh.up_wrap", int'(hours), 0);
      press(0, 0, 1);
      // ADJ_M: 0 -> 59, up wraps to 0 without touching hours, back to 59.
      press(1, 0, 0);
      press(0, 0, 1);
      check("adjm.down_wrap", int'(minutes), 59);
      press(0, 1, 0);
      check("adjm.up_wrap.m", int'(minutes), 0);
      check("adjm.up_wrap.h", int'(hours), 23);
      press(0, 0, 1);
      // Ticks are dropped while adjusting.
      repeat (5) do_tick();
      check("adjm.ticks_ignored", int'(seconds), 0);
      // Blink follows only the selected field.
      @(negedge clk); blink = 1'b1;
      #1;
      check("blink.m_on", int'(blank_m), 1);
      check("blink.h_off", int'(blank_h), 0);
      check("blink.s_off", int'(blank_s), 0);
      @(negedge clk); blink = 1'b0;
      #1;
      check("blink.m_off", int'(blank_m), 0);
      // ADJ_S: 0 -> 58, then up+down together changes nothing.
      press(1, 0, 0);
      press(0, 0, 1);
      press(0, 0, 1);
      press(0, 1, 1);
      check("coll.updown", int'(seconds), 58);
      press(1, 0, 0);
      check("run.back", int'(mode), 0);
      check_time("preload", 23, 59, 58);

      // Rollover; minutes stay put until seconds pass 59.
      do_tick();
      check_time("roll1", 23, 59, 59);
      do_tick();
      check_time("roll2", 0, 0, 0);

      // RUN ignores up/down and never blanks.
      press(0, 1, 0);
      @(negedge clk); blink = 1'b1;
      #1;
      check("run.blank_h", int'(blank_h), 0);
      check("run.blank_m", int'(blank_m), 0);
      check("run.blank_s", int'(blank_s), 0);
      @(negedge clk); blink = 1'b0;
      check_time("run.updown_ignored", 0, 0, 0);

      // Mode + up together in ADJ_H: mode wins.
      press(1, 0, 0);
      press(1, 1, 0);
      check("coll.mode_up.mode", int'(mode), 2);
      check("coll.mode_up.h", int'(hours), 0);
      press(1, 0, 0);
      press(1, 0, 0);
      repeat (10) do_tick();
      check_time("run10", 0, 0, 10);

      // Tick arriving on the same edge as the mode press.
      @(negedge clk); btn_mode = 1'b1;
      @(negedge clk);
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      #1;
      check("coll.tick_mode.mode", int'(mode), 1);
      check_time("coll.tick_mode", 0, 0, 11);
      repeat (3) @(negedge clk);
      btn_mode = 1'b0;
      repeat (4) @(negedge clk);

      // Set 12:34:56 and return to RUN.
      repeat (12) press(0, 1, 0);
      press(1, 0, 0);
      repeat (34) press(0, 1, 0);
      press(1, 0, 0);
      repeat (45) press(0, 1, 0);
      press(1, 0, 0);
      check_time("set", 12, 34, 56);
      check("set.mode", int'(mode), 0);

      // Short asynchronous reset between edges.
      @(negedge clk);
      #1 reset = 1'b0;
      #0.5;
      check("arst.mode", int'(mode), 0);
      check("arst.adj_en", int'(adj_en), 0);
      check_time("arst", 0, 0, 0);
      #0.5 reset = 1'b1;
      repeat (3) @(negedge clk);
      do_tick();
      check_time("arst.resume", 0, 0, 1);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
